// File: rtl/cpu_run_controller.sv
// Run controller: holds the CPU in reset, lets it run until halt, timeout or abort,
// and collects cycle, stall and branch-prediction statistics for the run.
module cpu_run_controller #(
  parameter int unsigned      CW           = 32,
  parameter int unsigned      RESET_CYCLES = 4,
  parameter longint unsigned  MAX_CLOCKS   = 1000
) (
  input  logic          input_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          hlt,
  input  logic          stall,
  input  logic          branch_valid,
  input  logic          branch_miss,
  output logic          cpu_rst,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [CW-1:0] cycles,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] bp_count,
  output logic [CW-1:0] bp_miss_count
);

  // state | meaning
  // IDLE  | CPU held in reset, waiting for start
  // RESET | CPU held in reset for RESET_CYCLES edges
  // RUN   | CPU clock enabled, statistics counting
  // DONE  | CPU frozen, results held until next start
  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  localparam logic [1:0]    ST_NONE  = 2'b00;
  localparam logic [1:0]    ST_HALT  = 2'b01;
  localparam logic [1:0]    ST_TOUT  = 2'b10;
  localparam logic [1:0]    ST_ABORT = 2'b11;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CLOCKS);
  localparam logic [7:0]    RST_LAST = 8'(RESET_CYCLES - 1);

  state_t        r_state;
  logic [7:0]    r_rst_cnt;
  logic [1:0]    r_status;
  logic [CW-1:0] r_cycles;
  logic [CW-1:0] r_stall;
  logic [CW-1:0] r_bp;
  logic [CW-1:0] r_miss;
  logic [CW-1:0] w_cyc_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CW'(1) : v;
  endfunction

  assign w_cyc_next = sat_inc(r_cycles, 1'b1);

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= '0;
      r_status  <= ST_NONE;
      r_cycles  <= '0;
      r_stall   <= '0;
      r_bp      <= '0;
      r_miss    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RESET;
            r_rst_cnt <= '0;
            r_status  <= ST_NONE;
            r_cycles  <= '0;
            r_stall   <= '0;
            r_bp      <= '0;
            r_miss    <= '0;
          end
        end
        S_RESET: begin
          if (abort) begin
            r_state  <= S_DONE;
            r_status <= ST_ABORT;
          end else if (r_rst_cnt == RST_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
          end
        end
        S_RUN: begin
          // The terminating edge is still counted, whichever condition ends the run.
          r_cycles <= w_cyc_next;
          r_stall  <= sat_inc(r_stall, stall);
          r_bp     <= sat_inc(r_bp, branch_valid);
          r_miss   <= sat_inc(r_miss, branch_valid & branch_miss);
          if (abort) begin
            r_state  <= S_DONE;
            r_status <= ST_ABORT;
          end else if (hlt) begin
            r_state  <= S_DONE;
            r_status <= ST_HALT;
          end else if (w_cyc_next == MAX_C) begin
            r_state  <= S_DONE;
            r_status <= ST_TOUT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rst       = (r_state == S_IDLE) || (r_state == S_RESET);
  assign cpu_run       = (r_state == S_RUN);
  assign busy          = (r_state == S_RESET) || (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign status        = r_status;
  assign cycles        = r_cycles;
  assign stall_count   = r_stall;
  assign bp_count      = r_bp;
  assign bp_miss_count = r_miss;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed and randomized bench for cpu_run_controller with a run-level reference model.
module tb_cpu_run_controller;
  localparam int CW = 32;
  localparam int RC = 4;
  localparam int MC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, hlt = 1'b0, stall = 1'b0, bv = 1'b0, bm = 1'b0;
  logic cpu_rst, cpu_run, busy, done;
  logic [1:0] status;
  logic [CW-1:0] cycles, stall_count, bp_count, bp_miss_count;

  int checks = 0;
  int errors = 0;
  int m_cyc, m_st, m_bp, m_miss, m_status;

  cpu_run_controller #(.CW(CW), .RESET_CYCLES(RC), .MAX_CLOCKS(MC)) dut (
    .input_clk(clk), .rst(rst_n), .start(start), .abort(abort), .hlt(hlt),
    .stall(stall), .branch_valid(bv), .branch_miss(bm),
    .cpu_rst(cpu_rst), .cpu_run(cpu_run), .busy(busy), .done(done), .status(status),
    .cycles(cycles), .stall_count(stall_count), .bp_count(bp_count),
    .bp_miss_count(bp_miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_rst, input bit e_run,
                            input bit e_busy, input bit e_done);
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(e_rst));
    chk({tag, ".cpu_run"}, 32'(cpu_run), 32'(e_run));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, ".status"}, 32'(status), 32'(m_status));
    chk({tag, ".cycles"}, cycles, 32'(m_cyc));
    chk({tag, ".stall"}, stall_count, 32'(m_st));
    chk({tag, ".bp"}, bp_count, 32'(m_bp));
    chk({tag, ".miss"}, bp_miss_count, 32'(m_miss));
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; hlt = 0; stall = 0; bv = 0; bm = 0;
  endtask

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic start_run(input bit hold_start);
    start = 1;
    @(negedge clk);
    start = hold_start;
    m_cyc = 0; m_st = 0; m_bp = 0; m_miss = 0; m_status = 0;
    check_outs("rst_ph0", 1, 0, 1, 0);
    check_cnts("rst_ph0");
    for (int i = 1; i < RC; i++) begin
      stall = 1'($urandom); hlt = 1'($urandom); bv = 1; bm = 1;
      @(negedge clk);
      check_outs("rst_ph", 1, 0, 1, 0);
    end
    @(negedge clk);
    idle_inputs();
    check_outs("run_entry", 0, 1, 1, 0);
    check_cnts("run_entry");
  endtask

  task automatic run_phase(input int hlt_at, input int abort_at, input bit rnd,
                           input logic [15:0] sm, input logic [15:0] bvm, input logic [15:0] bmm);
    bit ended = 0;
    for (int k = 1; k <= MC + 2 && !ended; k++) begin
      if (rnd) begin
        stall = 1'($urandom); bv = 1'($urandom); bm = 1'($urandom); start = 1'($urandom);
      end else begin
        stall = sm[k-1]; bv = bvm[k-1]; bm = bmm[k-1];
      end
      hlt = (k == hlt_at);
      abort = (k == abort_at);
      m_cyc++;
      if (stall) m_st++;
      if (bv) begin
        m_bp++;
        if (bm) m_miss++;
      end
      if (abort) m_status = 3;
      else if (hlt) m_status = 1;
      else if (m_cyc == MC) m_status = 2;
      ended = (m_status != 0);
      @(negedge clk);
      idle_inputs();
      if (ended) check_outs("done", 0, 0, 0, 1);
      else check_outs("run", 0, 1, 1, 0);
      check_cnts("run");
    end
  endtask

  task automatic hold_done(input int n);
    for (int i = 0; i < n; i++) begin
      stall = 1'($urandom); bv = 1'($urandom); bm = 1'($urandom);
      hlt = 1'($urandom); abort = 1'($urandom);
      @(negedge clk);
      idle_inputs();
      check_outs("hold", 0, 0, 0, 1);
      check_cnts("hold");
    end
  endtask

  initial begin
    m_cyc = 0; m_st = 0; m_bp = 0; m_miss = 0; m_status = 0;
    #12;
    check_outs("por", 1, 0, 0, 0);
    check_cnts("por");
    @(negedge clk);
    rst_n = 1;
    abort = 1; hlt = 1; stall = 1;
    @(negedge clk);
    idle_inputs();
    check_outs("idle_ign", 1, 0, 0, 0);
    check_cnts("idle_ign");

    // halt on 5th RUN edge
    start_run(0);
    run_phase(5, 0, 0, 16'h0, 16'h0, 16'h0);
    chk("halt5.cycles", cycles, 32'd5);
    chk("halt5.status", 32'(status), 32'd1);
    hold_done(3);

    // restart from DONE, timeout
    start_run(1);
    run_phase(0, 0, 0, 16'h0, 16'h0, 16'h0);
    chk("tout.cycles", cycles, 32'd10);
    chk("tout.status", 32'(status), 32'd2);

    // halt coinciding with timeout
    start_run(0);
    run_phase(10, 0, 0, 16'h0, 16'h0, 16'h0);
    chk("halt10.status", 32'(status), 32'd1);

    // statistics pattern, including a miss without valid
    start_run(0);
    run_phase(6, 0, 0, 16'h0015, 16'h002B, 16'h0006);
    chk("stats.stall", stall_count, 32'd3);
    chk("stats.bp", bp_count, 32'd4);
    chk("stats.miss", bp_miss_count, 32'd1);
    chk("stats.cycles", cycles, 32'd6);

    // abort beats halt
    start_run(0);
    run_phase(3, 3, 0, 16'h0, 16'h0, 16'h0);
    chk("abort3.status", 32'(status), 32'd3);
    chk("abort3.cycles", cycles, 32'd3);

    // abort during the CPU reset phase
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    idle_inputs();
    m_cyc = 0; m_st = 0; m_bp = 0; m_miss = 0; m_status = 3;
    check_outs("rst_abort", 0, 0, 0, 1);
    check_cnts("rst_abort");

    repeat (8) begin
      start_run(1'($urandom));
      run_phase($urandom_range(0, 12), $urandom_range(0, 12), 1, 16'h0, 16'h0, 16'h0);
      hold_done(2);
    end

    // asynchronous reset mid-run
    start_run(0);
    stall = 1; bv = 1;
    repeat (2) @(negedge clk);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    m_cyc = 0; m_st = 0; m_bp = 0; m_miss = 0; m_status = 0;
    check_outs("async_rst", 1, 0, 0, 0);
    check_cnts("async_rst");
    @(posedge clk);
    #1;
    check_outs("rst_hold", 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    start_run(0);
    run_phase(4, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("post_rst.cycles", cycles, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter CW, default 32, the width of all counters.
REQ-002 SHALL have parameter RESET_CYCLES, default 4, the number of cycles the CPU reset is held (range 1..255).
REQ-003 SHALL have parameter MAX_CLOCKS, default 1000, the RUN-cycle timeout limit (range 1..2^CW-1).
REQ-004 SHALL have port input_clk  in  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  level, sampled each edge; starts a run.
REQ-007 SHALL have port abort  in  1  level; terminates an active run.
REQ-008 SHALL have port hlt  in  1  the CPU retired the halt instruction this cycle.
REQ-009 SHALL have port stall  in  1  a CPU pipeline stall occurred this cycle.
REQ-010 SHALL have port branch_valid  in  1  a branch prediction was resolved this cycle.
REQ-011 SHALL have port branch_miss  in  1  the resolved prediction was wrong; qualified by branch_valid.
REQ-012 SHALL have port cpu_rst  out  1  active-high reset driven to the CPU.
REQ-013 SHALL have port cpu_run  out  1  CPU clock-enable.
REQ-014 SHALL have port busy  out  1  high in RESET or RUN.
REQ-015 SHALL have port done  out  1  high in DONE.
REQ-016 SHALL have port status  out  2  run result: 00 none, 01 halted, 10 timeout, 11 aborted.
REQ-017 SHALL have ports cycles, stall_count, bp_count and bp_miss_count  out  CW each  the run statistics counters.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, RESET, RUN and DONE; cpu_rst, cpu_run, busy and done SHALL be decoded from the state register only.
REQ-019 SHALL use these per-state output values: IDLE cpu_rst=1, cpu_run=0; RESET cpu_rst=1, cpu_run=0; RUN cpu_rst=0, cpu_run=1; DONE cpu_rst=0, cpu_run=0 (CPU state frozen for inspection).
REQ-020 SHALL, on an edge with start=1 in IDLE or DONE, go to RESET, clear all four counters, set status=00, and load the reset counter to 0.
REQ-021 SHALL ignore start in RESET and RUN.
REQ-022 SHALL stay in RESET for exactly RESET_CYCLES edges, then enter RUN.
REQ-023 SHALL, on each RUN edge, increment cycles by 1, including the edge on which hlt is sampled.
REQ-024 SHALL, on each RUN edge, increment stall_count when stall=1, increment bp_count when branch_valid=1, and increment bp_miss_count when branch_valid=1 and branch_miss=1; branch_miss with branch_valid=0 SHALL be ignored.
REQ-025 SHALL, when a RUN edge samples hlt=1, go to DONE with status=01.
REQ-026 SHALL, when a RUN edge samples hlt=0 and the incremented cycles value equals MAX_CLOCKS, go to DONE with status=10.
REQ-027 SHALL give hlt priority when hlt=1 coincides with reaching MAX_CLOCKS: status=01.
REQ-028 SHALL, when abort=1 on a RESET or RUN edge, go to DONE with status=11, taking priority over hlt and timeout; the RUN counters still count that edge.
REQ-029 SHALL ignore abort in IDLE and DONE.
REQ-030 SHALL make all counters saturate at 2^CW-1 and never wrap.
REQ-031 SHALL update counters only in RUN; counters and status SHALL hold their values in DONE until the next start.
REQ-032 SHALL ignore stall, branch_valid, branch_miss and hlt outside RUN.

Reset
REQ-033 SHALL, while rst=0, immediately (asynchronously) force state=IDLE, all counters=0, status=00, cpu_rst=1, cpu_run=0, busy=0 and done=0.
REQ-034 SHALL, when rst is asserted mid-run, discard that run with no DONE pulse.
REQ-035 SHALL resume normal operation on the first edge after rst deasserts; start SHALL be honoured on that edge.

Verification (RESET_CYCLES=4, MAX_CLOCKS=10, CW=32)
REQ-036 SHALL cover: start sampled at edge E -> cpu_rst=1 through edge E+4, cpu_run=1 and busy=1 from after edge E+4.
REQ-037 SHALL cover: hlt=1 on the 5th RUN edge -> cycles=5, status=01, done=1, cpu_run=0 after that edge.
REQ-038 SHALL cover: hlt never asserted -> DONE after the 10th RUN edge with cycles=10 and status=10; a second case with hlt=1 on the 10th RUN edge -> status=01.
REQ-039 SHALL cover: in a 6-cycle run, stall=1 on 3 edges and branch_valid=1 on 4 edges (miss on 1), plus one edge with branch_miss=1 and branch_valid=0 -> stall_count=3, bp_count=4, bp_miss_count=1.
REQ-040 SHALL cover: abort=1 on the 3rd RUN edge while hlt=1 -> status=11 and cycles=3.
REQ-041 SHALL cover: rst=0 mid-RUN -> all outputs at reset values without waiting for a clock edge; a new start after release -> counters restart from 0.
REQ-042 SHALL cover: start=1 in DONE -> counters cleared and a new RESET phase of 4 edges.
